jt12_slot_peek: RTL and testbench
=================================

# jt12_slot_peek

Slot-addressed reader for the time-multiplexed operator/channel rings built from the codebase's delay-line shift registers. It watches the serial slot stream at a ring tap and counts slots from a slot-0 sync marker. On request it captures the value of one chosen slot and returns it with a request/acknowledge handshake. It sits beside the FM pipeline and serves debug/CPU readback of per-slot state (phase, envelope, key-on) without disturbing the ring.

## Interface
Parameters:
- `width`, 5: bits per slot value
- `stages`, 24: slots per ring frame; must be ≥ 3
- `SW`, `$clog2(stages)`: slot index width

Ports:
- `clk` in 1: system clock
- `rst_n` in 1: reset, asynchronous, active-low
- `clk_en` in 1: ring advance enable, the same enable that shifts the ring
- `din` in `width`: ring stream at the tap; carries one slot per `clk_en` cycle
- `sync` in 1: qualified by `clk_en`; high when `din` carries slot 0
- `req` in 1: read request; level, held until `ack`
- `slot` in `SW`: requested slot index; sampled when the request is accepted
- `busy` out 1: request accepted and not yet acknowledged
- `ack` out 1: one-cycle pulse; `dout` and `err` are valid in the same cycle
- `dout` out `width`: captured slot value; holds until the next `ack`
- `err` out 1: set with `ack` when `slot` ≥ `stages`
- `locked` out 1: slot counter has seen at least one `sync`

## Operation
- Slot counter `cnt` advances only on `clk_en` cycles.
- Effective index `cur = sync ? 0 : cnt`.
- On `clk_en`: `cnt <= (cur == stages-1) ? 0 : cur+1`.
- `locked` sets on the first `clk_en && sync` and stays set until reset.
- A `sync` at an unexpected position resynchronises silently; any pending request continues against the new alignment.
- FSM states:
  - IDLE:
    - On `req`, latch `slot` into `slot_q` and set `busy`.
    - If `slot` ≥ `stages`, go to DONE with `err=1` and do not update `dout`.
    - Otherwise go to SEEK.
  - SEEK: on `clk_en && locked && cur == slot_q`, do `dout <= din` and go to DONE.
  - DONE: pulse `ack` for one cycle, clear `busy`, return to IDLE.
- `slot` is ignored while `busy`.
- `req` still high in the cycle after `ack` starts a new request. The requester must drop `req` in the `ack` cycle to avoid a repeat read.
- Reset mid-request: the FSM returns to IDLE and the request is lost; no `ack` is issued.
- Reset values: `busy=0`, `ack=0`, `dout=0`, `err=0`, `locked=0`, `cnt=0`, FSM in IDLE.

## Timing
- IDLE→SEEK: 1 clk after `req` is sampled.
- Capture occurs on the matching `clk_en` edge. `ack` rises on the next clk edge; it is registered, one clk after capture.
- Worst-case latency from acceptance with `locked=1`: `stages` `clk_en` cycles + 2 clk.
- While unlocked, SEEK waits indefinitely. The first `sync` can itself be the capture point when `slot_q == 0`.
- `clk_en` low freezes `cnt` and the SEEK progress; the DONE→IDLE path does not depend on `clk_en`.
- Invalid slot: `ack` with `err` is issued 2 clk after `req` is sampled.

## Configuration
- `JT12_SLOT_PEEK_SNAPSHOT_EN` defined:
  - The block keeps a `stages`×`width` snapshot array, written at index `cur` on every `clk_en` once locked.
  - A valid request whose slot has been written at least once since lock skips SEEK and acks 2 clk after `req`, returning the most recent snapshot.
  - A request for a slot not yet written since lock falls back to SEEK.
  - Snapshot valid bits clear on reset.
- Macro undefined: no array; always the SEEK behaviour above.

## Structure
- Shared package `jt12_peek_pkg` holds:
  - FSM state typedef (IDLE, SEEK, DONE)
  - default `STAGES=24` and `WIDTH=5` constants
  - a function computing the next slot index with wrap
- Sub-module `jt12_slot_cnt`: the `cnt`/`sync`/`locked` logic, reusable by other ring taps.
- The snapshot array stays in the top, under the macro.

## Test plan
- Lock and read: stream `din = slot index + 3`, `sync` on slot 0, `req` with `slot=5` → `ack` with `dout=8`, `err=0`, within 24 `clk_en` + 2 clk.
- Invalid slot: `req` with `slot=30` → `ack` with `err=1` 2 clk later; `dout` unchanged.
- Request before lock: `req` with `slot=0`, `sync` first raised 10 cycles later → capture on that `sync` cycle, `ack` 1 clk after it.
- `clk_en` gaps: `clk_en` high 1 in 3 clocks, `slot=23` → captured value equals slot 23 data, and `cnt` wraps 23→0 correctly.
- Resync: while seeking slot 10, inject `sync` at `cnt=6` → capture occurs 10 `clk_en` after the new `sync`.
- Reset mid-SEEK: deassert `rst_n` → all outputs 0, no `ack`, `locked=0`.
- With `JT12_SLOT_PEEK_SNAPSHOT_EN`: after one full frame, `req` with `slot=7` → `ack` 2 clk later with `dout=10`.

Source files
------------

// File: rtl/jt12_peek_pkg.sv
// Shared types and helpers for slot-addressed ring readers.
// Holds the reader FSM encoding, default ring geometry and the slot wrap rule.
package jt12_peek_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        DONE = 2'd2
    } peek_state_t;

    localparam int STAGES = 24;
    localparam int WIDTH  = 5;

    // Slot index that follows cur in a ring of n_slots slots.
    function automatic logic [31:0] next_slot(input logic [31:0] cur, input int n_slots);
        return (cur == 32'(n_slots - 1)) ? 32'd0 : cur + 32'd1;
    endfunction

endpackage

// File: rtl/jt12_slot_cnt.sv
// Slot counter for a ring tap: tracks the slot index from the slot-0 sync marker
// and reports lock once a marker has been seen.
module jt12_slot_cnt
    import jt12_peek_pkg::*;
#(
    parameter int stages = STAGES,
    parameter int SW     = $clog2(stages)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    input  logic          sync,
    output logic [SW-1:0] cur,
    output logic          locked
);

    logic [SW-1:0] cnt_reg;
    logic          locked_reg;

    // A marker anywhere overrides the running count, which gives silent resync.
    assign cur    = sync ? '0 : cnt_reg;
    assign locked = locked_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            locked_reg <= 1'b0;
        end else if (clk_en) begin
            cnt_reg <= SW'(next_slot(32'(cur), stages));
            if (sync)
                locked_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/jt12_slot_peek.sv
// Slot-addressed reader for a time-multiplexed ring with req/ack handshake.
// Optional JT12_SLOT_PEEK_SNAPSHOT_EN keeps a per-slot snapshot for fast reads.
module jt12_slot_peek
    import jt12_peek_pkg::*;
#(
    parameter int width  = WIDTH,
    parameter int stages = STAGES,
    parameter int SW     = $clog2(stages)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic [width-1:0] din,
    input  logic             sync,
    input  logic             req,
    input  logic [SW-1:0]    slot,
    output logic             busy,
    output logic             ack,
    output logic [width-1:0] dout,
    output logic             err,
    output logic             locked
);

    logic [SW-1:0] cur;

    jt12_slot_cnt #(
        .stages (stages),
        .SW     (SW)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .sync   (sync),
        .cur    (cur),
        .locked (locked)
    );

    peek_state_t      state_reg, state_next;
    logic [SW-1:0]    slot_q_reg, slot_q_next;
    logic [width-1:0] cap_reg, cap_next;
    logic             err_q_reg, err_q_next;
    logic             ack_reg, ack_next;
    logic [width-1:0] dout_reg, dout_next;
    logic             err_reg, err_next;
    logic             lock_now;
    logic             hit;
    logic             slot_bad;

    // The first marker already counts as locked so slot 0 can be caught on it.
    assign lock_now = locked | sync;
    assign hit      = clk_en && lock_now && (cur == slot_q_reg);
    assign slot_bad = (32'(slot) >= 32'(stages));

`ifdef JT12_SLOT_PEEK_SNAPSHOT_EN
    logic [width-1:0] snap_mem [stages];
    logic [stages-1:0] snap_vld_reg;
    logic [width-1:0] snap_rd_reg;
    logic [SW-1:0]    slot_idx;
    logic             use_snap_reg, use_snap_next;

    assign slot_idx = slot_bad ? '0 : slot;

    always_ff @(posedge clk) begin
        if (clk_en && lock_now)
            snap_mem[cur] <= din;
        snap_rd_reg <= snap_mem[slot_idx];
    end

    generate
        for (genvar gi = 0; gi < stages; gi++) begin : g_vld
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    snap_vld_reg[gi] <= 1'b0;
                else if (clk_en && lock_now && (32'(cur) == gi))
                    snap_vld_reg[gi] <= 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            use_snap_reg <= 1'b0;
        else
            use_snap_reg <= use_snap_next;
    end
`endif

    always_comb begin
        state_next  = state_reg;
        slot_q_next = slot_q_reg;
        cap_next    = cap_reg;
        err_q_next  = err_q_reg;
        ack_next    = 1'b0;
        dout_next   = dout_reg;
        err_next    = err_reg;
`ifdef JT12_SLOT_PEEK_SNAPSHOT_EN
        use_snap_next = use_snap_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (req) begin
                    slot_q_next = slot;
                    err_q_next  = slot_bad;
`ifdef JT12_SLOT_PEEK_SNAPSHOT_EN
                    use_snap_next = 1'b0;
                    if (slot_bad) begin
                        state_next = DONE;
                    end else if (snap_vld_reg[slot_idx]) begin
                        use_snap_next = 1'b1;
                        state_next    = DONE;
                    end else begin
                        state_next = SEEK;
                    end
`else
                    state_next = slot_bad ? DONE : SEEK;
`endif
                end
            end
            SEEK: begin
                if (hit) begin
                    cap_next   = din;
                    state_next = DONE;
                end
            end
            DONE: begin
                ack_next   = 1'b1;
                err_next   = err_q_reg;
                state_next = IDLE;
                // An invalid slot leaves the previous readback in place.
                if (!err_q_reg) begin
`ifdef JT12_SLOT_PEEK_SNAPSHOT_EN
                    dout_next = use_snap_reg ? snap_rd_reg : cap_reg;
`else
                    dout_next = cap_reg;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            slot_q_reg <= '0;
            cap_reg    <= '0;
            err_q_reg  <= 1'b0;
            ack_reg    <= 1'b0;
            dout_reg   <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            slot_q_reg <= slot_q_next;
            cap_reg    <= cap_next;
            err_q_reg  <= err_q_next;
            ack_reg    <= ack_next;
            dout_reg   <= dout_next;
            err_reg    <= err_next;
        end
    end

    assign busy = (state_reg != IDLE);
    assign ack  = ack_reg;
    assign dout = dout_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_jt12_slot_peek.sv
// Self-checking bench for jt12_slot_peek: directed scenarios plus randomized reads
// compared every cycle against a deadline-based behavioural model.
module tb_jt12_slot_peek;

    localparam int STAGES = 24;
    localparam int WIDTH  = 5;
    localparam int SW     = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clk_en = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             sync = 1'b0;
    logic             req = 1'b0;
    logic [SW-1:0]    slot = '0;
    logic             busy, ack, err, locked;
    logic [WIDTH-1:0] dout;

    always #5 clk = ~clk;

    jt12_slot_peek #(.width(WIDTH), .stages(STAGES), .SW(SW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .din    (din),
        .sync   (sync),
        .req    (req),
        .slot   (slot),
        .busy   (busy),
        .ack    (ack),
        .dout   (dout),
        .err    (err),
        .locked (locked)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // ring stream generator
    logic [WIDTH-1:0] ring_val [STAGES];
    int gen_pos = 0;
    int en_period = 1;      // 0 selects random enable
    int phase = 0;
    bit sync_on = 1'b1;

    // behavioural model: slot position since marker plus ack deadline
    int               m_cnt;
    bit               m_locked;
    bit               m_seek;
    int               m_slot;
    int               m_ack_due;
    logic [WIDTH-1:0] m_pend_dout, m_dout;
    bit               m_pend_err, m_err;
    bit               e_ack, e_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_locked = 0; m_seek = 0; m_slot = 0; m_ack_due = -1;
        m_pend_dout = '0; m_dout = '0; m_pend_err = 0; m_err = 0;
        e_ack = 0; e_busy = 0;
    endtask

    // Predict the effect of the coming clock edge (edge number cyc).
    task automatic model_edge();
        int pos;
        bit mark;
        mark = clk_en && sync;
        pos  = mark ? 0 : m_cnt;
        e_ack = (m_ack_due == cyc);
        if (e_ack) begin
            m_dout = m_pend_dout;
            m_err  = m_pend_err;
        end
        if (m_seek) begin
            if (clk_en && (m_locked || mark) && pos == m_slot) begin
                m_seek = 0; m_ack_due = cyc + 1; m_pend_dout = din; m_pend_err = 0;
            end
        end else if (m_ack_due != cyc && req) begin
            m_slot = int'(slot);
            if (m_slot >= STAGES) begin
                m_ack_due = cyc + 1; m_pend_dout = m_dout; m_pend_err = 1;
            end else begin
                m_seek = 1;
            end
        end
        e_busy = m_seek || (m_ack_due == cyc + 1);
        if (clk_en) begin
            m_cnt = (pos + 1) % STAGES;
            if (mark) m_locked = 1;
        end
    endtask

    task automatic tick(input bit force_sync);
        bit en;
        en = (en_period == 0) ? ($urandom_range(0, 2) != 0) : ((phase % en_period) == 0);
        phase++;
        if (force_sync) gen_pos = 0;
        clk_en = en;
        if (en) begin
            din  = ring_val[gen_pos];
            sync = sync_on && (gen_pos == 0);
            gen_pos = (gen_pos + 1) % STAGES;
        end else begin
            din  = WIDTH'($urandom);
            sync = 1'($urandom_range(0, 1));
        end
        model_edge();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check("ack", 32'(ack), 32'(e_ack));
        check("busy", 32'(busy), 32'(e_busy));
        check("locked", 32'(locked), 32'(m_locked));
        check("dout", 32'(dout), 32'(m_dout));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic do_read(input int sl, input int budget, output bit got,
                           output logic [WIDTH-1:0] d, output bit e, output int lat);
        int start;
        start = cyc; got = 0; d = '0; e = 0; lat = 0;
        req = 1'b1;
        slot = SW'(sl);
        for (int i = 0; i < budget && !got; i++) begin
            tick(1'b0);
            if (ack) begin
                got = 1; d = dout; e = err; lat = cyc - start;
                req = 1'b0;
                $display("read slot %0d -> dout %0h err %0d latency %0d", sl, d, e, lat);
            end else if (busy) begin
                slot = SW'($urandom);
            end
        end
        req = 1'b0;
        check("ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        @(posedge clk); cyc++;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    bit               got, e;
    logic [WIDTH-1:0] d;
    int               lat, sync_cyc;

    initial begin
        model_reset();
        for (int i = 0; i < STAGES; i++) ring_val[i] = WIDTH'(i + 3);
        @(negedge clk);
        do_reset();

        // lock then read slot 5 of a slot+3 stream
        gen_pos = 0;
        for (int i = 0; i < 30; i++) tick(1'b0);
        check("locked_after_sync", 32'(locked), 32'd1);
        do_read(5, 40, got, d, e, lat);
        check("read5_dout", 32'(d), 32'd8);
        check("read5_err", 32'(e), 32'd0);
        check("read5_latency_le26", 32'(lat <= 26), 32'd1);

        // invalid slot: err after 2 clk, dout kept
        do_read(30, 10, got, d, e, lat);
        check("bad_err", 32'(e), 32'd1);
        check("bad_dout_kept", 32'(d), 32'd8);
        check("bad_latency", 32'(lat), 32'd2);

        // request before lock, capture on the first marker
        do_reset();
        for (int i = 0; i < STAGES; i++) ring_val[i] = WIDTH'($urandom);
        sync_on = 1'b0;
        req = 1'b1; slot = '0;
        for (int i = 0; i < 10; i++) tick(1'b0);
        check("prelock_waiting", 32'(busy), 32'd1);
        sync_on = 1'b1;
        tick(1'b1);
        check("prelock_no_ack_on_capture", 32'(ack), 32'd0);
        tick(1'b0);
        req = 1'b0;
        check("prelock_ack", 32'(ack), 32'd1);
        check("prelock_dout", 32'(dout), 32'(ring_val[0]));
        $display("prelock read slot 0 -> dout %0h", dout);

        // sparse clk_en, last slot and counter wrap without markers
        en_period = 3;
        do_read(23, 120, got, d, e, lat);
        check("gap23_dout", 32'(d), 32'(ring_val[23]));
        sync_on = 1'b0;
        do_read(1, 120, got, d, e, lat);
        check("wrap1_dout", 32'(d), 32'(ring_val[1]));
        sync_on = 1'b1;

        // resync while seeking slot 10
        en_period = 1;
        for (int i = 0; i < STAGES && gen_pos != 0; i++) tick(1'b0);
        req = 1'b1; slot = SW'(10);
        tick(1'b0);
        for (int i = 0; i < STAGES && gen_pos != 6; i++) tick(1'b0);
        tick(1'b1);
        sync_cyc = cyc;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick(1'b0);
            if (ack) begin got = 1; lat = cyc - sync_cyc; d = dout; end
        end
        req = 1'b0;
        $display("resync read slot 10 -> dout %0h after %0d clk", d, lat);
        check("resync_ack", 32'(got), 32'd1);
        check("resync_delay", 32'(lat), 32'd11);
        check("resync_dout", 32'(d), 32'(ring_val[10]));

        // reset in the middle of a seek
        req = 1'b1; slot = SW'(20);
        tick(1'b0); tick(1'b0); tick(1'b0);
        check("midseek_busy", 32'(busy), 32'd1);
        do_reset();
        sync_on = 1'b0;
        for (int i = 0; i < 30; i++) tick(1'b0);
        sync_on = 1'b1;
        $display("reset mid-seek: busy %0d ack %0d locked %0d", busy, ack, locked);

        // randomized reads against the model
        en_period = 0;
        for (int i = 0; i < STAGES; i++) ring_val[i] = WIDTH'($urandom);
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int i = 0; i < gap; i++) tick(1'b0);
            do_read($urandom_range(0, 31), 200, got, d, e, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
